// File: rtl/gf2_pkg.sv
// gf2_pkg: shared types and width helpers for the GF(2) polynomial divider.
//   gf2_state_t  : divider control states (IDLE, BUSY, DONE)
//   GF2_M        : default field size
//   gf2_cnt_w()  : bit-counter width for a given field size
//   gf2_idx_w()  : leading-one index width for an (M+1)-bit divisor
package gf2_pkg;

    localparam int GF2_M = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } gf2_state_t;

    // The counter walks dividend bit indices N-1 .. 0, where N = 2*M-1.
    function automatic int gf2_cnt_w(input int m);
        return (2 * m - 1 > 1) ? $clog2(2 * m - 1) : 1;
    endfunction

    // Must hold any index 0..M.
    function automatic int gf2_idx_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/gf2_lead_one.sv
// gf2_lead_one: combinational priority encoder returning the index of the
// most significant set bit, i.e. the degree of a GF(2) polynomial.
//   vec : (M+1)-bit polynomial, bit i = coeff of x^i
//   idx : index of the highest set bit; 0 when vec is zero
module gf2_lead_one
    import gf2_pkg::*;
#(
    parameter  int M  = GF2_M,
    localparam int IW = gf2_idx_w(M)
) (
    input  logic [M:0]    vec,
    output logic [IW-1:0] idx
);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        idx = '0;
        for (int i = 0; i <= M; i++) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/gf2_poly_divider.sv
// gf2_poly_divider: sequential GF(2) polynomial long divider.
// Computes a(x) = q(x)*d(x) + r(x) and retires one dividend bit per clock.
// The latency is fixed at N cycles from accept to out_valid.
// Optional feature macro: GF2_DIV_ZERO_CHK_EN. It adds the err_div0 port and
// a short path for a zero divisor.
//   clk, rst            : clock; synchronous active-high reset
//   in_valid / in_ready : input handshake; in_ready is high only in IDLE
//   dividend [N-1:0]    : a(x), N = 2*M-1
//   divisor  [M:0]      : d(x), degree <= M
//   out_valid/out_ready : output handshake; results are held until accepted
//   quotient [N-1:0]    : q(x)
//   remainder[M-1:0]    : r(x), deg r < deg d
//   err_div0            : divisor was zero (only with GF2_DIV_ZERO_CHK_EN)
module gf2_poly_divider
    import gf2_pkg::*;
#(
    parameter  int M  = GF2_M,
    localparam int N  = 2 * M - 1,
    localparam int CW = gf2_cnt_w(M),
    localparam int IW = gf2_idx_w(M)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [M:0]   divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder
`ifdef GF2_DIV_ZERO_CHK_EN
    ,
    output logic         err_div0
`endif
);

    gf2_state_t    state, state_nx;
    logic [N-1:0]  a_q;
    logic [M-1:0]  d_lo;   // divisor without x^M; see the reduction note below
    logic [IW-1:0] dg, dg_in;
    logic [M-1:0]  r;
    logic [N-1:0]  q;
    logic [CW-1:0] cnt;
    logic [M:0]    r_sh;
    logic [M-1:0]  r_nx;
    logic          hit;
    logic          accept;

    gf2_lead_one #(.M(M)) u_lead_one (
        .vec (divisor),
        .idx (dg_in)
    );

    assign accept    = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign quotient  = q;
    assign remainder = r;

    // One long-division step. Bit M of the reduced value is never stored.
    // If dg == M, the xor clears it. If dg < M, it was already zero because
    // deg r < dg before the shift. With a zero divisor, truncating that bit
    // still leaves a[M-1:0] in the remainder.
    always_comb begin
        r_sh = {r, a_q[cnt]};
        hit  = r_sh[dg];
        r_nx = hit ? (r_sh[M-1:0] ^ d_lo) : r_sh[M-1:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)   state_nx = BUSY;
            BUSY:    if (cnt == '0)  state_nx = DONE;
            DONE:    if (out_ready)  state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            d_lo  <= '0;
            dg    <= '0;
            r     <= '0;
            q     <= '0;
            cnt   <= '0;
`ifdef GF2_DIV_ZERO_CHK_EN
            err_div0 <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q  <= dividend;
                d_lo <= divisor[M-1:0];
                dg   <= dg_in;
                r    <= '0;
                q    <= '0;
                cnt  <= CW'(N - 1);
`ifdef GF2_DIV_ZERO_CHK_EN
                err_div0 <= (divisor == '0);
                // A zero divisor runs a single step on a zeroed dividend.
                // This reaches DONE one edge later with q = r = 0.
                if (divisor == '0) begin
                    a_q <= '0;
                    cnt <= '0;
                end
`endif
            end else if (state == BUSY) begin
                r      <= r_nx;
                q[cnt] <= hit;
                cnt    <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gf2_poly_divider.sv
// tb_gf2_poly_divider: randomized self-checking bench for gf2_poly_divider (M=8).
// The reference model does textbook polynomial long division on 32-bit integers.
module tb_gf2_poly_divider;

    localparam int M = 8;
    localparam int N = 2 * M - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid;
    logic [N-1:0] dividend = '0;
    logic [M:0]   divisor = '0;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
`ifdef GF2_DIV_ZERO_CHK_EN
    logic         err_div0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gf2_poly_divider #(.M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef GF2_DIV_ZERO_CHK_EN
        ,
        .err_div0  (err_div0)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pdeg(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] clmul(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) if (x[i]) p ^= (y << i);
        return p;
    endfunction

    task automatic ref_div(input logic [N-1:0] a, input logic [M:0] d,
                           output logic [N-1:0] q, output logic [M-1:0] r);
        logic [31:0] rem, qq;
        int dd, s;
        rem = 32'(a);
        qq  = '0;
        dd  = pdeg(32'(d));
        if (dd < 0) begin
`ifdef GF2_DIV_ZERO_CHK_EN
            q = '0; r = '0;
`else
            q = a;  r = a[M-1:0];
`endif
            return;
        end
        while (pdeg(rem) >= dd) begin
            s = pdeg(rem) - dd;
            rem ^= (32'(d) << s);
            qq  |= (32'd1 << s);
        end
        q = qq[N-1:0];
        r = rem[M-1:0];
    endtask

    // Accept one operation, then count edges until out_valid is seen.
    task automatic do_op(input logic [N-1:0] a, input logic [M:0] d, output int lat);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
        dividend = a;
        divisor  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid) chk("timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic finish_out(input int delay);
        repeat (delay) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ovalid_clr", 32'(out_valid), 32'd0);
        chk("iready_back", 32'(in_ready), 32'd1);
    endtask

    logic [N-1:0] da [4] = '{15'h0100, 15'h0057, 15'h0005, 15'h1234};
    logic [M:0]   dd [4] = '{9'h11B, 9'h11B, 9'h003, 9'h001};
    logic [N-1:0] dq [4] = '{15'h0001, 15'h0000, 15'h0003, 15'h1234};
    logic [M-1:0] dr [4] = '{8'h1B, 8'h57, 8'h00, 8'h00};

    initial begin
        int lat;
        logic [N-1:0] a, eq;
        logic [M:0]   d;
        logic [M-1:0] er;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
`ifdef GF2_DIV_ZERO_CHK_EN
        chk("rst_err", 32'(err_div0), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            do_op(da[i], dd[i], lat);
            chk("dir_lat", 32'(lat), 32'd15);
            chk("dir_q", 32'(quotient), 32'(dq[i]));
            chk("dir_r", 32'(remainder), 32'(dr[i]));
            finish_out(0);
        end

        // While DONE holds, outputs must stay stable and in_valid must be ignored.
        do_op(15'h0100, 9'h11B, lat);
        for (int i = 0; i < 5; i++) begin
            dividend = 15'($urandom);
            divisor  = 9'($urandom_range(1, 511));
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_q", 32'(quotient), 32'h0001);
            chk("hold_r", 32'(remainder), 32'h1B);
        end
        finish_out(0);

        // Reset in the middle of BUSY aborts the operation.
        dividend = 15'h7FFF;
        divisor  = 9'h11B;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        rst = 1'b0;
        do_op(15'h7FFF, 9'h11B, lat);
        ref_div(15'h7FFF, 9'h11B, eq, er);
        chk("post_rst_q", 32'(quotient), 32'(eq));
        chk("post_rst_r", 32'(remainder), 32'(er));
        finish_out(1);

        // Zero divisor.
        do_op(15'h2A5C, 9'h000, lat);
`ifdef GF2_DIV_ZERO_CHK_EN
        chk("div0_lat", 32'(lat), 32'd1);
        chk("div0_err", 32'(err_div0), 32'd1);
        chk("div0_q", 32'(quotient), 32'd0);
        chk("div0_r", 32'(remainder), 32'd0);
`else
        chk("div0_lat", 32'(lat), 32'd15);
        chk("div0_q", 32'(quotient), 32'h2A5C);
        chk("div0_r", 32'(remainder), 32'h5C);
`endif
        finish_out(0);
`ifdef GF2_DIV_ZERO_CHK_EN
        do_op(15'h0100, 9'h11B, lat);
        chk("div0_err_clr", 32'(err_div0), 32'd0);
        finish_out(0);
`endif

        for (int i = 0; i < 1000; i++) begin
            a = 15'($urandom);
            d = 9'($urandom_range(1, 511));
            do_op(a, d, lat);
            ref_div(a, d, eq, er);
            chk("rnd_lat", 32'(lat), 32'd15);
            chk("rnd_q", 32'(quotient), 32'(eq));
            chk("rnd_r", 32'(remainder), 32'(er));
            chk("rnd_recon", clmul(32'(quotient), 32'(d)) ^ 32'(remainder), 32'(a));
            chk("rnd_deg", 32'(pdeg(32'(remainder)) < pdeg(32'(d))), 32'd1);
            finish_out($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
